// File: rtl/dot_product_seq.sv
// -----------------------------------------------------------------------------
// dot_product_seq
//
// Sequencing stage around a purely combinational 4x4 array multiplier.
// Operand pairs arrive over a valid/ready handshake and are registered onto
// the multiplier inputs. Each returned product is accumulated one cycle later.
// After LEN pairs the dot product is presented on an output handshake and is
// held until the consumer takes it.
//
// Parameters:
//   LEN        pairs per dot product, 1..15
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair present
//   in_ready   block accepts a pair this cycle (RUN state, not in reset)
//   in_a/in_b  4-bit unsigned operands
//   mul_a/b    registered operands driven to the multiplier
//   mul_r      16-bit product returned by the multiplier
//   out_valid  dot product available (held until out_ready)
//   out_ready  consumer takes the result
//   out_sum    accumulated dot product, meaningful while out_valid
// -----------------------------------------------------------------------------
module dot_product_seq #(
    parameter int LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [15:0] mul_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] acc_q,   acc_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        pend_q,  pend_d;
    logic [3:0]  mul_a_q, mul_a_d;
    logic [3:0]  mul_b_q, mul_b_d;
    logic        accept;

    assign in_ready  = rst_n & (state_q == RUN);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == OUT);
    assign out_sum   = acc_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

    always_comb begin
        // NOTE: every signal gets a hold default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;

        // The product of the operands registered last cycle is on mul_r now.
        if (pend_q) begin
            acc_d = acc_q + mul_r;
        end

        unique case (state_q)
            RUN: begin
                if (accept) begin
                    mul_a_d = in_a;
                    mul_b_d = in_b;
                    pend_d  = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end else begin
                    pend_d = 1'b0;
                end
            end
            DRAIN: begin
                // The final product is being added this cycle.
                pend_d  = 1'b0;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    acc_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; reset is sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            acc_q   <= 16'd0;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            mul_a_q <= 4'd0;
            mul_b_q <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

endmodule

// File: tb/tb_dot_product_seq.sv
// -----------------------------------------------------------------------------
// tb_dot_product_seq
//
// Three instances (LEN = 4, 15, 1) share clock and reset. Each has its own
// behavioural multiplier (mul_r = mul_a * mul_b). Expected dot products are
// computed directly as the sum of a*b over the vector, modulo 2^16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_dot_product_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [3:0]  in_a      [3];
    logic [3:0]  in_b      [3];
    logic [3:0]  mul_a     [3];
    logic [3:0]  mul_b     [3];
    logic [15:0] mul_r     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] out_sum   [3];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_accept_cyc = 0;

    logic [3:0] va [16];
    logic [3:0] vb [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dot_product_seq #(.LEN(4)) u_len4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_r(mul_r[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(out_sum[0])
    );

    dot_product_seq #(.LEN(15)) u_len15 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_r(mul_r[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(out_sum[1])
    );

    dot_product_seq #(.LEN(1)) u_len1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]),
        .mul_a(mul_a[2]), .mul_b(mul_b[2]), .mul_r(mul_r[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(out_sum[2])
    );

    // Behavioural combinational multipliers.
    assign mul_r[0] = 16'(mul_a[0]) * 16'(mul_b[0]);
    assign mul_r[1] = 16'(mul_a[1]) * 16'(mul_b[1]);
    assign mul_r[2] = 16'(mul_a[2]) * 16'(mul_b[2]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send n pairs from va/vb to instance idx with random idle gaps of up to
    // max_gap cycles, then check the result timing and value. The consumer
    // stalls for 'hold' cycles after out_valid rises.
    task automatic run_vec(input int idx, input int n, input int max_gap,
                           input int hold, input string tag);
        int exp;
        int t;
        exp = 0;
        for (int i = 0; i < n; i++) exp += int'(va[i]) * int'(vb[i]);
        exp = exp % 65536;
        out_ready[idx] = (hold == 0);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            in_valid[idx] = 1'b0;
            repeat (gap) step();
            in_valid[idx] = 1'b1;
            in_a[idx] = va[i];
            in_b[idx] = vb[i];
            t = 0;
            while (!in_ready[idx] && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                check({tag, "_accept_timeout"}, 0, 1);
                in_valid[idx] = 1'b0;
                return;
            end
            step();
            last_accept_cyc = cyc;
            if (i < n - 1) begin
                check({tag, "_early_out_valid"}, 32'(out_valid[idx]), 0);
            end
        end
        in_valid[idx] = 1'b0;
        // One edge after the last accept: DRAIN, nothing presented yet.
        check({tag, "_drain_out_valid"}, 32'(out_valid[idx]), 0);
        check({tag, "_drain_in_ready"}, 32'(in_ready[idx]), 0);
        step();
        check({tag, "_out_valid_rise"}, 32'(out_valid[idx]), 1);
        check({tag, "_sum"}, 32'(out_sum[idx]), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_hold_valid"}, 32'(out_valid[idx]), 1);
            check({tag, "_hold_sum"}, 32'(out_sum[idx]), 32'(exp));
            check({tag, "_hold_in_ready"}, 32'(in_ready[idx]), 0);
        end
        out_ready[idx] = 1'b1;
        step();
        check({tag, "_out_valid_fall"}, 32'(out_valid[idx]), 0);
        check({tag, "_in_ready_back"}, 32'(in_ready[idx]), 1);
    endtask

    initial begin
        int prev;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_a[i] = 4'd0;
            in_b[i] = 4'd0;
            out_ready[i] = 1'b0;
        end

        // ---------------- reset and idle ----------------
        rst_n = 1'b0;
        step();
        step();
        check("in_ready_in_reset", 32'(in_ready[0]), 0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", 32'(in_ready[i]), 1);
            check("rst_out_valid", 32'(out_valid[i]), 0);
            check("rst_out_sum", 32'(out_sum[i]), 0);
            check("rst_mul_a", 32'(mul_a[i]), 0);
            check("rst_mul_b", 32'(mul_b[i]), 0);
        end
        out_ready[0] = 1'b1;  // ignored while out_valid is low
        for (int c = 0; c < 6; c++) begin
            step();
            check("idle_in_ready", 32'(in_ready[0]), 1);
            check("idle_out_valid", 32'(out_valid[0]), 0);
            check("idle_out_sum", 32'(out_sum[0]), 0);
        end

        // ---------------- LEN=4 directed back-to-back ----------------
        for (int i = 0; i < 4; i++) begin
            va[i] = 4'(2 * i + 1);
            vb[i] = 4'(2 * i + 2);
        end
        run_vec(0, 4, 0, 0, "len4_b2b");

        // ---------------- LEN=15 (15,15) with gaps ----------------
        for (int i = 0; i < 15; i++) begin
            va[i] = 4'd15;
            vb[i] = 4'd15;
        end
        run_vec(1, 15, 3, 0, "len15_max");

        // ---------------- LEN=4 stalled consumer, then acc cleared ----------
        for (int i = 0; i < 4; i++) begin
            va[i] = 4'(2 * i + 1);
            vb[i] = 4'(2 * i + 2);
        end
        run_vec(0, 4, 0, 5, "len4_stall");
        for (int i = 0; i < 4; i++) begin
            va[i] = 4'd2;
            vb[i] = 4'd2;
        end
        run_vec(0, 4, 0, 0, "len4_after_stall");

        // ---------------- LEN=4 reset mid-vector ----------------
        in_valid[0] = 1'b1;
        in_a[0] = 4'd15;
        in_b[0] = 4'd15;
        step();
        step();
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        step();
        check("midrst_in_ready_low", 32'(in_ready[0]), 0);
        rst_n = 1'b1;
        #1;
        check("midrst_mul_a", 32'(mul_a[0]), 0);
        check("midrst_mul_b", 32'(mul_b[0]), 0);
        check("midrst_out_sum", 32'(out_sum[0]), 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("midrst_out_valid", 32'(out_valid[0]), 0);
        end
        for (int i = 0; i < 4; i++) begin
            va[i] = 4'd1;
            vb[i] = 4'd1;
        end
        run_vec(0, 4, 0, 0, "len4_after_rst");

        // ---------------- LEN=1 ----------------
        va[0] = 4'd9;  vb[0] = 4'd9;
        run_vec(2, 1, 0, 0, "len1_a");
        prev = last_accept_cyc;
        va[0] = 4'd0;  vb[0] = 4'd15;
        run_vec(2, 1, 0, 0, "len1_b");
        check("len1_period", 32'(last_accept_cyc - prev), 3);
        prev = last_accept_cyc;
        va[0] = 4'd15; vb[0] = 4'd1;
        run_vec(2, 1, 0, 0, "len1_c");
        check("len1_period", 32'(last_accept_cyc - prev), 3);

        // ---------------- randomized vectors ----------------
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++) begin
                va[i] = 4'($urandom_range(0, 15));
                vb[i] = 4'($urandom_range(0, 15));
            end
            run_vec(0, 4, 2, int'($urandom_range(0, 3)), "len4_rand");
        end
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 15; i++) begin
                va[i] = 4'($urandom_range(0, 15));
                vb[i] = 4'($urandom_range(0, 15));
            end
            run_vec(1, 15, 2, int'($urandom_range(0, 2)), "len15_rand");
        end
        for (int v = 0; v < 5; v++) begin
            va[0] = 4'($urandom_range(0, 15));
            vb[0] = 4'($urandom_range(0, 15));
            run_vec(2, 1, 1, int'($urandom_range(0, 2)), "len1_rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
